// File: rtl/ahb_master_if_if.sv
// ---------------------------------------------------------------------------
// ahb_master_if_if
// Bundles the signals of the single-transfer AHB master into one interface.
// The bundle covers the local request/response handshake and the AHB-side
// arbiter and bus signals.
//   master modport : the ahb_master_if block (drives req_ready, rsp_*, hreq,
//                    sel, haddr, hwrite, htrans, hwdata).
//   slave  modport : the environment (local requester, arbiter, slave).
// Clock and reset are not part of the bundle. They stay scalar ports of
// the block.
// ---------------------------------------------------------------------------
interface ahb_master_if_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Local request / response side
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_slave;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    // Arbiter and AHB bus side
    logic              hreq;
    logic              hgrant;
    logic [1:0]        sel;
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic              hresp;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_slave,
        input  hgrant, hrdata, hready, hresp,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output hreq, sel, haddr, hwrite, htrans, hwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_slave,
        output hgrant, hrdata, hready, hresp,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  hreq, sel, haddr, hwrite, htrans, hwdata
    );
endinterface

// File: rtl/ahb_master_if.sv
// ---------------------------------------------------------------------------
// ahb_master_if
// This is a single-outstanding AHB master. It accepts one local request,
// then asks the arbiter for the bus. When the bus is granted, it runs one
// NONSEQ address phase and then a data phase with a wait-state timeout.
// It reports the result on a one-cycle response strobe.
// Ports:
//   hclk    : clock. All state updates happen on its rising edge.
//   hreset  : synchronous active-high reset. It aborts any transfer in
//             progress and produces no response.
//   bus     : ahb_master_if_if.master. It carries the local
//             req_*/rsp_* handshake and the AHB/arbiter signals.
// Every output comes straight from a flop. Each output flop is loaded with
// the value that belongs to the state being entered, so output timing
// matches the state register.
// ---------------------------------------------------------------------------
module ahb_master_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic              hclk,
    input logic              hreset,
    ahb_master_if_if.master  bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0]       HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]       HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_e;

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        slave_q, slave_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              hreq_q, hreq_d;
    logic [1:0]        sel_q, sel_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        slave_d     = slave_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        // Next state. Requests are latched only in IDLE, and hgrant only
        // matters in REQ.
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    slave_d = bus.req_slave;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.hgrant) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                state_d = ST_DATA;
                cnt_d   = '0;
            end
            ST_DATA: begin
                if (bus.hready) begin
                    state_d = ST_RESP;
                    if (bus.hresp)     rsp_err_d   = 1'b1;
                    else if (!write_q) rsp_rdata_d = bus.hrdata;
                end else begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    // This wait cycle brings the count to TIMEOUT, so give up.
                    if (cnt_q >= CNT_LAST) begin
                        state_d   = ST_RESP;
                        rsp_err_d = 1'b1;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Output flops take the values of the state being entered.
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        hreq_d      = 1'b0;
        sel_d       = '0;
        haddr_d     = '0;
        hwrite_d    = 1'b0;
        htrans_d    = HTRANS_IDLE;
        hwdata_d    = '0;
        case (state_d)
            ST_IDLE: req_ready_d = 1'b1;
            ST_REQ: begin
                hreq_d = 1'b1;
                sel_d  = slave_d;
            end
            ST_ADDR: begin
                htrans_d = HTRANS_NONSEQ;
                haddr_d  = addr_d;
                hwrite_d = write_d;
                sel_d    = slave_d;
            end
            ST_DATA: begin
                sel_d    = slave_d;
                hwdata_d = write_d ? wdata_d : '0;
            end
            ST_RESP: rsp_valid_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge hclk) begin
        // NOTE: all state updates here are non-blocking, so every flop
        // samples the pre-edge values regardless of statement order.
        if (hreset) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            slave_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            hreq_q      <= 1'b0;
            sel_q       <= '0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            hwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            slave_q     <= slave_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            hreq_q      <= hreq_d;
            sel_q       <= sel_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            htrans_q    <= htrans_d;
            hwdata_q    <= hwdata_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.hreq      = hreq_q;
    assign bus.sel       = sel_q;
    assign bus.haddr     = haddr_q;
    assign bus.hwrite    = hwrite_q;
    assign bus.htrans    = htrans_q;
    assign bus.hwdata    = hwdata_q;
endmodule

// File: tb/tb_ahb_master_if.sv
// ---------------------------------------------------------------------------
// tb_ahb_master_if
// Directed bench for ahb_master_if. The cases are: reset values, a
// zero-wait read, a write with wait states, a slave error, a wait-state
// timeout, a delayed grant with ignored extra requests, and a reset in the
// middle of a transfer. Expected values are written by hand in the
// stimulus.
// ---------------------------------------------------------------------------
module tb_ahb_master_if;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic hclk;
    logic hreset;
    int   checks;
    int   failures;
    int   n;

    ahb_master_if_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ahb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .hclk  (hclk),
        .hreset(hreset),
        .bus   (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // Issue one request, hold the grant off for gnt_delay cycles, and step
    // into the first DATA cycle. It checks the REQ and ADDR phases on the way.
    // While the grant is held off, it pushes conflicting requests. These must
    // be ignored.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input int gnt_delay);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_slave = s;
        tick();
        bus.req_valid = 1'b0;
        check("req_hreq_sel_ready", {60'd0, bus.hreq, bus.sel, bus.req_ready}, {60'd0, 1'b1, s, 1'b0});
        for (int i = 0; i < gnt_delay; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = ~a;
            bus.req_write = ~w;
            tick();
            check("gnt_wait_hreq_htrans_ready", {60'd0, bus.hreq, bus.htrans, bus.req_ready}, 64'h8);
        end
        bus.req_valid = 1'b0;
        bus.req_addr  = a;
        bus.req_write = w;
        bus.hgrant    = 1'b1;
        tick();
        bus.hgrant = 1'b0;
        check("addr_htrans", {62'd0, bus.htrans}, 64'h2);
        check("addr_haddr", {32'd0, bus.haddr}, {32'd0, a});
        check("addr_hwrite_hreq_sel", {60'd0, bus.hwrite, bus.hreq, bus.sel}, {60'd0, w, 1'b0, s});
        tick();
        check("data_htrans_sel", {60'd0, bus.htrans, bus.sel}, {60'd0, 2'b00, s});
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        hreset        = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_slave = '0;
        bus.hgrant    = 1'b0;
        bus.hrdata    = '0;
        bus.hready    = 1'b0;
        bus.hresp     = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_outputs_zero",
              {bus.req_ready, bus.hreq, bus.htrans, bus.hwrite, bus.sel, bus.rsp_valid,
               bus.rsp_err, bus.haddr, bus.hwdata, bus.rsp_rdata}, '0);
        hreset = 1'b0;
        tick();
        check("rst_release_ready", {63'd0, bus.req_ready}, 64'd1);

        // A grant while IDLE is ignored
        bus.hgrant = 1'b1;
        tick();
        bus.hgrant = 1'b0;
        check("idle_grant_ignored", {60'd0, bus.hreq, bus.htrans, bus.req_ready}, 64'h1);

        // Read, zero wait
        bus.hready = 1'b1;
        bus.hrdata = 32'hDEADBEEF;
        issue(1'b0, 32'h40, 32'hAAAA5555, 2'd1, 0);
        check("rd_hwdata_zero", {32'd0, bus.hwdata}, 64'd0);
        tick();
        check("rd_rsp", {31'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {31'd0, 1'b1, 1'b0, 32'hDEADBEEF});
        tick();
        check("rd_back_idle", {62'd0, bus.rsp_valid, bus.req_ready}, 64'h1);

        // Write with 3 wait states
        bus.hrdata = 32'hCAFEF00D;
        issue(1'b1, 32'h100, 32'h12345678, 2'd2, 0);
        bus.hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wr_hwdata_wait", {31'd0, bus.rsp_valid, bus.hwdata}, {32'd0, 32'h12345678});
            tick();
        end
        check("wr_hwdata_last", {31'd0, bus.rsp_valid, bus.hwdata}, {32'd0, 32'h12345678});
        bus.hready = 1'b1;
        tick();
        check("wr_rsp", {31'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {31'd0, 1'b1, 1'b0, 32'd0});
        tick();
        check("wr_single_pulse", {63'd0, bus.rsp_valid}, 64'd0);

        // Slave error
        bus.hresp  = 1'b1;
        bus.hrdata = 32'h55555555;
        issue(1'b0, 32'h200, 32'd0, 2'd3, 0);
        tick();
        bus.hresp = 1'b0;
        check("err_rsp", {31'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {31'd0, 1'b1, 1'b1, 32'd0});
        tick();
        check("err_back_idle", {62'd0, bus.rsp_valid, bus.req_ready}, 64'h1);

        // Timeout: the response must arrive on the 16th wait edge
        issue(1'b0, 32'h300, 32'd0, 2'd0, 0);
        bus.hready = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check("to_wait_cycles", 64'(n), 64'd16);
        check("to_rsp", {31'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {31'd0, 1'b1, 1'b1, 32'd0});
        bus.hready = 1'b1;
        tick();
        check("to_back_idle", {62'd0, bus.rsp_valid, bus.req_ready}, 64'h1);

        // Grant delay of 10 cycles, with conflicting requests ignored
        bus.hrdata = 32'h0BADF00D;
        issue(1'b1, 32'h400, 32'hA5A5A5A5, 2'd1, 10);
        check("gd_hwdata", {32'd0, bus.hwdata}, {32'd0, 32'hA5A5A5A5});
        tick();
        check("gd_rsp", {31'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {31'd0, 1'b1, 1'b0, 32'd0});
        tick();

        // Reset in the middle of DATA
        issue(1'b1, 32'h500, 32'h77778888, 2'd2, 0);
        bus.hready = 1'b0;
        tick();
        hreset = 1'b1;
        tick();
        check("mid_rst_outputs_zero",
              {bus.req_ready, bus.hreq, bus.htrans, bus.hwrite, bus.sel, bus.rsp_valid,
               bus.rsp_err, bus.haddr, bus.hwdata, bus.rsp_rdata}, '0);
        hreset     = 1'b0;
        bus.hready = 1'b1;
        tick();
        check("mid_rst_release", {62'd0, bus.rsp_valid, bus.req_ready}, 64'h1);
        tick();
        check("mid_rst_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
